// File: rtl/wb_systolic_engine.sv
// Wishbone-mapped sequencer for a ROWS x COLS systolic array: loads weights from a private word RAM,
// streams N_VEC activation vectors through the array and writes the COLS results per vector back to RAM.
module wb_systolic_engine #(
   parameter int ROWS      = 4,
   parameter int COLS      = 4,
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 2048,
   parameter int ARRAY_LAT = ROWS + COLS
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          wb_cyc,
   input  logic                          wb_stb,
   input  logic                          wb_we,
   input  logic [15:0]                   wb_adr,
   input  logic [3:0]                    wb_sel,
   input  logic [31:0]                   wb_dat_w,
   output logic [31:0]                   wb_dat_r,
   output logic                          wb_ack,
   output logic                          wb_err,
   output logic                          irq,
   output logic                          arr_wload,
   output logic [ROWS*DATA_W-1:0]        arr_in,
   output logic [ROWS*COLS*DATA_W-1:0]   arr_w,
   input  logic [COLS*2*DATA_W-1:0]      arr_out
);
   localparam int AW = $clog2(DEPTH);
   localparam int RC = ROWS * COLS;
   localparam logic [15:0] ADR_CSR = 16'hFE00, ADR_WB = 16'hFE04, ADR_AB = 16'hFE08,
                           ADR_OB = 16'hFE0C, ADR_NV = 16'hFE10, ADR_CY = 16'hFE14;

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD_W, S_WLATCH, S_GATHER, S_ISSUE, S_WAIT, S_CAPTURE, S_WRITE, S_DONE
   } state_t;

   state_t state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [31:0] vec_idx_q, vec_idx_d, cyc_cnt_q, cyc_cnt_d, cycles_q, cycles_d;
   logic [31:0] w_base_q, w_base_d, a_base_q, a_base_d, o_base_q, o_base_d, n_vec_q, n_vec_d;
   logic [AW-1:0] a_ptr_q, a_ptr_d, o_ptr_q, o_ptr_d;
   logic done_q, done_d, err_q, err_d, irq_en_q, irq_en_d;
   logic [RC*DATA_W-1:0]     arr_w_q, arr_w_d;
   logic [ROWS*DATA_W-1:0]   vec_q, vec_d;
   logic [COLS*2*DATA_W-1:0] res_q, res_d;
   logic wb_ack_q, wb_ack_d, wb_err_q, wb_err_d, rd_pend_q, rd_pend_d;
   logic [31:0] wb_dat_r_q, wb_dat_r_d, ram_rdata_q, ram_rdata_d;

   logic [31:0]   ram_q [DEPTH];
   logic          ram_re, ram_we;
   logic [AW-1:0] ram_addr;
   logic [31:0]   ram_wdata;
   logic [3:0]    ram_be;

   logic busy, bus_req, is_ram, start_acc, range_ok;
   logic [47:0] w_end, a_end, o_end;
   logic [31:0] csr_rd;

   assign busy    = (state_q != S_IDLE);
   assign bus_req = wb_cyc & wb_stb & ~wb_ack_q & ~wb_err_q & ~rd_pend_q;
   assign is_ram  = ({1'b0, wb_adr} < 17'(DEPTH * 4));
   assign csr_rd  = {27'b0, err_q, irq_en_q, done_q, busy, 1'b0};
   assign w_end   = {16'b0, w_base_q} + 48'(RC);
   assign a_end   = {16'b0, a_base_q} + {16'b0, n_vec_q} * 48'(ROWS);
   assign o_end   = {16'b0, o_base_q} + {16'b0, n_vec_q} * 48'(COLS);
   assign range_ok = (w_end <= 48'(DEPTH)) && (a_end <= 48'(DEPTH)) && (o_end <= 48'(DEPTH));

   always_comb begin
      state_d = state_q;     cnt_d = cnt_q;         vec_idx_d = vec_idx_q;
      cyc_cnt_d = cyc_cnt_q; cycles_d = cycles_q;
      w_base_d = w_base_q;   a_base_d = a_base_q;   o_base_d = o_base_q;   n_vec_d = n_vec_q;
      a_ptr_d = a_ptr_q;     o_ptr_d = o_ptr_q;
      done_d = done_q;       err_d = err_q;         irq_en_d = irq_en_q;
      arr_w_d = arr_w_q;     vec_d = vec_q;         res_d = res_q;
      wb_ack_d = 1'b0;       wb_err_d = 1'b0;       wb_dat_r_d = 32'b0;    rd_pend_d = 1'b0;
      ram_re = 1'b0;         ram_we = 1'b0;         ram_addr = '0;         ram_wdata = 32'b0;
      ram_be = 4'b0;         start_acc = 1'b0;

      // Bus side: RAM port is only reachable while the sequencer is idle.
      if (rd_pend_q) begin
         wb_ack_d   = 1'b1;
         wb_dat_r_d = ram_rdata_q;
      end else if (bus_req) begin
         if (is_ram) begin
            if (busy) begin
               wb_err_d = 1'b1;
            end else if (wb_we) begin
               ram_we    = 1'b1;
               ram_be    = wb_sel;
               ram_addr  = wb_adr[AW+1:2];
               ram_wdata = wb_dat_w;
               wb_ack_d  = 1'b1;
            end else begin
               ram_re    = 1'b1;
               ram_addr  = wb_adr[AW+1:2];
               rd_pend_d = 1'b1;
            end
         end else begin
            wb_ack_d = 1'b1;
            if (!wb_we) begin
               case (wb_adr)
                  ADR_CSR: wb_dat_r_d = csr_rd;
                  ADR_WB:  wb_dat_r_d = w_base_q;
                  ADR_AB:  wb_dat_r_d = a_base_q;
                  ADR_OB:  wb_dat_r_d = o_base_q;
                  ADR_NV:  wb_dat_r_d = n_vec_q;
                  ADR_CY:  wb_dat_r_d = cycles_q;
                  default: wb_dat_r_d = 32'b0;
               endcase
            end else begin
               case (wb_adr)
                  ADR_CSR: begin
                     if (wb_dat_w[2]) done_d = 1'b0;
                     if (wb_dat_w[4]) err_d  = 1'b0;
                     irq_en_d  = wb_dat_w[3];
                     start_acc = wb_dat_w[0] & ~busy;
                  end
                  ADR_WB:  if (!busy) w_base_d = wb_dat_w;
                  ADR_AB:  if (!busy) a_base_d = wb_dat_w;
                  ADR_OB:  if (!busy) o_base_d = wb_dat_w;
                  ADR_NV:  if (!busy) n_vec_d  = wb_dat_w;
                  default: ;
               endcase
            end
         end
      end

      if (busy && cyc_cnt_q != 32'hFFFF_FFFF) cyc_cnt_d = cyc_cnt_q + 32'd1;

      if (start_acc) begin
         if (!range_ok) begin
            err_d  = 1'b1;
            done_d = 1'b1;
         end else if (n_vec_q == 32'd0) begin
            done_d   = 1'b1;
            cycles_d = 32'd1;
         end else begin
            state_d   = S_LOAD_W;
            cnt_d     = 16'd0;
            vec_idx_d = 32'd0;
            a_ptr_d   = a_base_q[AW-1:0];
            o_ptr_d   = o_base_q[AW-1:0];
            cyc_cnt_d = 32'd1;
         end
      end

      // Reads issue at cnt and land one cycle later, so read phases run one extra cycle.
      case (state_q)
         S_LOAD_W: begin
            if (cnt_q < 16'(RC)) begin
               ram_re   = 1'b1;
               ram_addr = w_base_q[AW-1:0] + AW'(cnt_q);
            end
            if (cnt_q != 16'd0) arr_w_d[(int'(cnt_q)-1)*DATA_W +: DATA_W] = ram_rdata_q[DATA_W-1:0];
            if (cnt_q == 16'(RC)) begin
               state_d = S_WLATCH;
               cnt_d   = 16'd0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_WLATCH: state_d = S_GATHER;
         S_GATHER: begin
            if (cnt_q < 16'(ROWS)) begin
               ram_re   = 1'b1;
               ram_addr = a_ptr_q + AW'(cnt_q);
            end
            if (cnt_q != 16'd0) vec_d[(int'(cnt_q)-1)*DATA_W +: DATA_W] = ram_rdata_q[DATA_W-1:0];
            if (cnt_q == 16'(ROWS)) begin
               state_d = S_ISSUE;
               cnt_d   = 16'd0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            if (cnt_q == 16'(ARRAY_LAT - 1)) begin
               state_d = S_CAPTURE;
               cnt_d   = 16'd0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_CAPTURE: begin
            res_d   = arr_out;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            ram_we    = 1'b1;
            ram_be    = 4'hF;
            ram_addr  = o_ptr_q + AW'(cnt_q);
            ram_wdata = 32'(res_q[int'(cnt_q)*2*DATA_W +: 2*DATA_W]);
            if (cnt_q == 16'(COLS - 1)) begin
               cnt_d   = 16'd0;
               o_ptr_d = o_ptr_q + AW'(COLS);
               a_ptr_d = a_ptr_q + AW'(ROWS);
               if (vec_idx_q == n_vec_q - 32'd1) begin
                  state_d = S_DONE;
               end else begin
                  vec_idx_d = vec_idx_q + 32'd1;
                  state_d   = S_GATHER;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_DONE: begin
            done_d   = 1'b1;
            cycles_d = cyc_cnt_q;
            state_d  = S_IDLE;
         end
         default: ;
      endcase

      ram_rdata_d = ram_re ? ram_q[ram_addr] : ram_rdata_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;   cnt_q <= '0;      vec_idx_q <= '0;  cyc_cnt_q <= '0;  cycles_q <= '0;
         w_base_q <= '0;      a_base_q <= '0;   o_base_q <= '0;   n_vec_q <= '0;
         a_ptr_q <= '0;       o_ptr_q <= '0;    done_q <= 1'b0;   err_q <= 1'b0;    irq_en_q <= 1'b0;
         arr_w_q <= '0;       vec_q <= '0;      res_q <= '0;
         wb_ack_q <= 1'b0;    wb_err_q <= 1'b0; wb_dat_r_q <= '0; rd_pend_q <= 1'b0; ram_rdata_q <= '0;
      end else begin
         state_q <= state_d;  cnt_q <= cnt_d;   vec_idx_q <= vec_idx_d; cyc_cnt_q <= cyc_cnt_d;
         cycles_q <= cycles_d;
         w_base_q <= w_base_d; a_base_q <= a_base_d; o_base_q <= o_base_d; n_vec_q <= n_vec_d;
         a_ptr_q <= a_ptr_d;  o_ptr_q <= o_ptr_d; done_q <= done_d; err_q <= err_d; irq_en_q <= irq_en_d;
         arr_w_q <= arr_w_d;  vec_q <= vec_d;   res_q <= res_d;
         wb_ack_q <= wb_ack_d; wb_err_q <= wb_err_d; wb_dat_r_q <= wb_dat_r_d;
         rd_pend_q <= rd_pend_d; ram_rdata_q <= ram_rdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (ram_we) begin
         for (int b = 0; b < 4; b++) begin
            if (ram_be[b]) ram_q[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
         end
      end
   end

   assign wb_ack    = wb_ack_q;
   assign wb_err    = wb_err_q;
   assign wb_dat_r  = wb_dat_r_q;
   assign irq       = done_q & irq_en_q;
   assign arr_wload = (state_q == S_WLATCH);
   assign arr_in    = (state_q == S_ISSUE) ? vec_q : '0;
   assign arr_w     = arr_w_q;
endmodule

// File: tb/tb_wb_systolic_engine.sv
// Directed bench for wb_systolic_engine in a 2x2 geometry with a behavioural array model.
module tb_wb_systolic_engine;
   localparam int ROWS = 2, COLS = 2, DATA_W = 8, DEPTH = 2048;
   localparam logic [15:0] CSR = 16'hFE00, WB = 16'hFE04, AB = 16'hFE08,
                           OB = 16'hFE0C, NV = 16'hFE10, CY = 16'hFE14;

   logic clk = 1'b0, rst_n = 1'b1;
   logic wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
   logic [15:0] wb_adr = '0;
   logic [3:0]  wb_sel = '0;
   logic [31:0] wb_dat_w = '0, wb_dat_r;
   logic wb_ack, wb_err, irq, arr_wload;
   logic [ROWS*DATA_W-1:0]      arr_in;
   logic [ROWS*COLS*DATA_W-1:0] arr_w;
   logic [COLS*2*DATA_W-1:0]    arr_out = '0;

   int errors = 0, checks = 0;

   always #5 clk = ~clk;

   wb_systolic_engine #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
      .wb_adr(wb_adr), .wb_sel(wb_sel), .wb_dat_w(wb_dat_w), .wb_dat_r(wb_dat_r),
      .wb_ack(wb_ack), .wb_err(wb_err), .irq(irq), .arr_wload(arr_wload),
      .arr_in(arr_in), .arr_w(arr_w), .arr_out(arr_out)
   );

   // Array model: latch weights on wload, compute and hold sum_r in[r]*w[r][c] on a nonzero issue.
   logic [DATA_W-1:0] wm [ROWS*COLS];
   int unsigned acc;
   always @(posedge clk) begin
      if (arr_wload) for (int k = 0; k < ROWS*COLS; k++) wm[k] <= arr_w[k*DATA_W +: DATA_W];
      if (arr_in != '0) begin
         for (int c = 0; c < COLS; c++) begin
            acc = 0;
            for (int r = 0; r < ROWS; r++)
               acc += int'(arr_in[r*DATA_W +: DATA_W]) * int'(wm[r*COLS+c]);
            arr_out[c*2*DATA_W +: 2*DATA_W] <= acc[15:0];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wb_xfer(input logic we, input logic [15:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd,
                          output logic ack, output logic err);
      @(negedge clk);
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = a; wb_dat_w = d; wb_sel = s;
      ack = 1'b0; err = 1'b0; rd = '0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (wb_ack || wb_err) begin
            ack = wb_ack; err = wb_err; rd = wb_dat_r;
            break;
         end
      end
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
   endtask

   task automatic wr(input logic [15:0] a, input logic [31:0] d);
      logic [31:0] rd; logic ack, err;
      wb_xfer(1'b1, a, d, 4'hF, rd, ack, err);
      chk($sformatf("wr_ack@%h", a), 32'(ack), 32'd1);
   endtask

   task automatic rd_chk(input logic [15:0] a, input logic [31:0] exp, input string tag);
      logic [31:0] rd; logic ack, err;
      wb_xfer(1'b0, a, 32'b0, 4'hF, rd, ack, err);
      chk({tag, "_ack"}, 32'(ack), 32'd1);
      chk(tag, rd, exp);
   endtask

   task automatic wait_done(input string tag);
      logic [31:0] rd; logic ack, err, ok;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         wb_xfer(1'b0, CSR, 32'b0, 4'hF, rd, ack, err);
         if (ack && rd[2]) begin ok = 1'b1; break; end
      end
      chk(tag, 32'(ok), 32'd1);
   endtask

   task automatic load_t1_data();
      wr(16'h0040, 1); wr(16'h0044, 0); wr(16'h0048, 0); wr(16'h004C, 1);
      wr(16'h0080, 1); wr(16'h0084, 2); wr(16'h0088, 3); wr(16'h008C, 4);
   endtask

   initial begin
      logic [31:0] rd; logic ack, err;

      #2 rst_n = 1'b0;
      #20;
      chk("rst_ctl", 32'({wb_ack, wb_err, irq, arr_wload}), 32'd0);
      chk("rst_arr_w", arr_w, 32'd0);
      chk("rst_arr_in", 32'(arr_in), 32'd0);
      chk("rst_dat_r", wb_dat_r, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      rd_chk(CSR, 32'h0, "rst_csr");
      rd_chk(CY, 32'h0, "rst_cycles");
      rd_chk(16'hFE40, 32'h0, "unmapped_rd");

      // Identity weights, two vectors
      load_t1_data();
      wr(WB, 16); wr(AB, 32); wr(OB, 48); wr(NV, 2);
      wr(CSR, 32'h9);
      wait_done("t1_done");
      rd_chk(CSR, 32'h0C, "t1_csr");
      chk("t1_irq", 32'(irq), 32'd1);
      rd_chk(16'h00C0, 1, "t1_o0"); rd_chk(16'h00C4, 2, "t1_o1");
      rd_chk(16'h00C8, 3, "t1_o2"); rd_chk(16'h00CC, 4, "t1_o3");
      rd_chk(CY, 32'd29, "t1_cycles");
      chk("t1_arr_w_hold", arr_w, 32'h0100_0001);
      chk("t1_arr_in_idle", 32'(arr_in), 32'd0);
      wr(CSR, 32'h0C);
      chk("t1_irq_clr", 32'(irq), 32'd0);

      // Saturating-width result, upper element bits ignored
      wr(16'h0040, 8'hFF); wr(16'h0044, 8'hFF); wr(16'h0048, 8'hFF); wr(16'h004C, 8'hFF);
      wr(16'h0080, 32'hABCD_00FF); wr(16'h0084, 32'h0000_00FF);
      wr(NV, 1);
      wr(CSR, 32'h1);
      wait_done("t2_done");
      rd_chk(16'h00C0, 32'h0000_FC02, "t2_o0");
      rd_chk(16'h00C4, 32'h0000_FC02, "t2_o1");
      rd_chk(16'h00C8, 32'd3, "t2_o2_untouched");
      wr(16'h00F0, 32'hAABB_CCDD);
      wb_xfer(1'b1, 16'h00F0, 32'h1122_3344, 4'b0101, rd, ack, err);
      chk("sel_wr_ack", 32'(ack), 32'd1);
      rd_chk(16'h00F0, 32'hAA22_CC44, "sel_merge");

      // Bus activity while busy
      wr(CSR, 32'h5);
      wr(CSR, 32'h1);
      wb_xfer(1'b0, 16'h0010, 32'b0, 4'hF, rd, ack, err);
      chk("t3_err", 32'(err), 32'd1);
      chk("t3_no_ack", 32'(ack), 32'd0);
      rd_chk(CSR, 32'h02, "t3_busy");
      wr(NV, 5);
      rd_chk(NV, 32'd1, "t3_nvec_kept");
      wait_done("t3_done");
      rd_chk(CSR, 32'h04, "t3_csr");
      rd_chk(CY, 32'd18, "t3_cycles");
      rd_chk(16'h00C0, 32'h0000_FC02, "t3_o0");

      // Out-of-range output region
      wr(16'h1FFC, 32'h1234_5678);
      wr(OB, DEPTH - 1);
      wr(CSR, 32'h5);
      rd_chk(CSR, 32'h14, "t4_err_done");
      rd_chk(16'h1FFC, 32'h1234_5678, "t4_ram_kept");
      wr(CSR, 32'h14);
      rd_chk(CSR, 32'h0, "t4_clr");

      // Zero-length run
      wr(OB, 48); wr(NV, 0);
      wr(CSR, 32'h1);
      rd_chk(CSR, 32'h04, "t5_done");
      rd_chk(CY, 32'd1, "t5_cycles");

      // Reset in the middle of WAIT
      load_t1_data();
      wr(16'h0100, 32'hDEAD); wr(16'h0104, 32'hDEAD);
      wr(16'h0108, 32'hDEAD); wr(16'h010C, 32'hDEAD);
      wr(WB, 16); wr(AB, 32); wr(OB, 64); wr(NV, 2);
      wr(CSR, 32'h5);
      repeat (11) @(posedge clk);
      #1;
      chk("t6_arr_w_loaded", arr_w, 32'h0100_0001);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_ctl", 32'({wb_ack, wb_err, irq, arr_wload}), 32'd0);
      chk("t6_rst_arr_w", arr_w, 32'd0);
      chk("t6_rst_arr_in", 32'(arr_in), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      rd_chk(CSR, 32'h0, "t6_csr_idle");
      rd_chk(WB, 32'h0, "t6_wbase_rst");
      rd_chk(16'h0100, 32'hDEAD, "t6_o_untouched");
      wr(WB, 16); wr(AB, 32); wr(OB, 64); wr(NV, 2);
      wr(CSR, 32'h1);
      wait_done("t6_done");
      rd_chk(16'h0100, 1, "t6_o0"); rd_chk(16'h0104, 2, "t6_o1");
      rd_chk(16'h0108, 3, "t6_o2"); rd_chk(16'h010C, 4, "t6_o3");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
